// File: rtl/l2_response_router.sv
// Routes L2 response packets into per-core FIFOs; broadcasts are copied to every core, all-or-nothing.
// Optional statistics outputs (rsp_count, drop_count) are enabled by defining L2RSP_ROUTER_STATS_EN.
module l2_response_router #(
  parameter int NUM_CORES    = 2,
  parameter int PACKET_WIDTH = 64,
  parameter int CORE_LSB     = 0,
  parameter int CORE_WIDTH   = 4,
  parameter int BCAST_BIT    = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              l2rsp_valid,
  input  logic [PACKET_WIDTH-1:0]           l2rsp_packet,
  output logic                              l2rsp_ready,
  output logic [NUM_CORES-1:0]              core_rsp_valid,
  output logic [NUM_CORES*PACKET_WIDTH-1:0] core_rsp_packet,
  input  logic [NUM_CORES-1:0]              core_rsp_ready,
  output logic                              bad_core_id
`ifdef L2RSP_ROUTER_STATS_EN
  ,
  output logic [31:0]                       rsp_count,
  output logic [15:0]                       drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [CORE_WIDTH-1:0] dest;
  logic [31:0]           dest_ext;
  logic                  bcast;
  logic [NUM_CORES-1:0]  tgt;
  logic [NUM_CORES-1:0]  full;
  logic [NUM_CORES-1:0]  push;
  logic [NUM_CORES-1:0]  pop;
  logic                  accept;
  logic                  drop;
  logic                  bad_core_id_q;
  logic                  bad_core_id_d;

  assign dest     = l2rsp_packet[CORE_LSB +: CORE_WIDTH];
  assign dest_ext = 32'(dest);
  assign bcast    = l2rsp_packet[BCAST_BIT];

  // An out-of-range id matches no core, so the target set is empty and ready stays high.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_tgt
    assign tgt[g] = bcast | (dest_ext == 32'(g));
  end

  assign l2rsp_ready = ~|(tgt & full);
  assign accept      = l2rsp_valid & l2rsp_ready;
  assign drop        = l2rsp_valid & ~|tgt;
  assign push        = tgt & {NUM_CORES{accept}};

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_fifo
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];

    assign full[g]           = (count_q == CW'(FIFO_DEPTH));
    assign core_rsp_valid[g] = (count_q != '0);
    assign pop[g]            = core_rsp_valid[g] & core_rsp_ready[g];
    assign core_rsp_packet[g*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[rd_ptr_q];

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push[g]) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop[g])  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push[g], pop[g]})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage carries data only; validity is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wr_ptr_q] <= l2rsp_packet;
    end
  end

  assign bad_core_id_d = bad_core_id_q | drop;
  assign bad_core_id   = bad_core_id_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bad_core_id_q <= 1'b0;
    else          bad_core_id_q <= bad_core_id_d;
  end

`ifdef L2RSP_ROUTER_STATS_EN
  logic [31:0] rsp_count_q, rsp_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    rsp_count_d  = rsp_count_q;
    drop_count_d = drop_count_q;
    if (accept && |tgt) rsp_count_d = rsp_count_q + 32'd1;
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      rsp_count_q  <= rsp_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rsp_count  = rsp_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule
